// File: rtl/phoneme_player_if.sv
// ----------------------------------------------------------------------------
// phoneme_player_if
// Command / sample-ROM / audio bundle for phoneme_player.
//   data     : 7-bit phoneme code (bits [5:0] used)       master -> slave
//   write    : single-cycle command strobe                master -> slave
//   busy     : command FIFO full, writes are dropped      slave  -> master
//   idle     : FIFO empty and nothing playing             slave  -> master
//   rom_addr : {code, sample_idx} sample ROM address      slave  -> master
//   rom_data : unsigned 8-bit sample, one clock after addr master -> slave
//   speaker  : registered PWM audio bit                   slave  -> master
// ----------------------------------------------------------------------------
interface phoneme_player_if #(
    parameter int SAMPLE_BITS = 10
);
    logic [6:0]               data;
    logic                     write;
    logic                     busy;
    logic                     idle;
    logic [6+SAMPLE_BITS-1:0] rom_addr;
    logic [7:0]               rom_data;
    logic                     speaker;

    modport master (
        output data, write, rom_data,
        input  busy, idle, rom_addr, speaker
    );

    modport slave (
        input  data, write, rom_data,
        output busy, idle, rom_addr, speaker
    );
endinterface

// File: rtl/phoneme_player.sv
// ----------------------------------------------------------------------------
// phoneme_player
// Queues phoneme codes in a small FIFO and plays each one as 2^SAMPLE_BITS
// samples read from an external ROM, one sample every CLK_DIV clocks, on a
// PWM speaker output.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : phoneme_player_if.slave (data/write/busy/idle/rom_addr/
//           rom_data/speaker)
// ----------------------------------------------------------------------------
module phoneme_player #(
    parameter int CLK_DIV     = 256,
    parameter int SAMPLE_BITS = 10,
    parameter int FIFO_LOG2   = 3
) (
    input  logic              clk,
    input  logic              reset,
    phoneme_player_if.slave   bus
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int DIV_W = $clog2(CLK_DIV);
    // LOAD and CAPTURE take one cycle each, HOLD runs DIV_LOAD..0 inclusive,
    // so a full sample period is exactly CLK_DIV cycles.
    localparam logic [DIV_W-1:0]       DIV_LOAD = DIV_W'(CLK_DIV - 3);
    localparam logic [SAMPLE_BITS-1:0] IDX_MAX  = '1;
    localparam logic [FIFO_LOG2:0]     FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [7:0]             SILENCE  = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [5:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_count;
    logic [FIFO_LOG2:0]   w_count_n;
    logic                 r_busy;
    logic                 r_idle;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [5:0]           w_head;
    logic                 w_unused_data6;

    // busy is registered from the post-edge occupancy, so it always
    // reflects the current count; a push is refused whenever it is high,
    // including the full-and-popping case.
    assign w_push         = bus.write & ~r_busy;
    assign w_empty        = (r_count == '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_unused_data6 = bus.data[6];

    always_comb begin
        w_count_n = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + 1'b1;
            2'b01:   w_count_n = r_count - 1'b1;
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.data[5:0];
    end

    // ------------------------------------------------------------------
    // Playback FSM
    // ------------------------------------------------------------------
    state_t                  r_state, w_state_n;
    logic [5:0]              r_code,  w_code_n;
    logic [SAMPLE_BITS-1:0]  r_idx,   w_idx_n;
    logic [DIV_W-1:0]        r_div,   w_div_n;
    logic [7:0]              r_sample, w_sample_n;
    logic [6+SAMPLE_BITS-1:0] r_rom_addr, w_rom_addr_n;
    logic [7:0]              r_pwm;
    logic                    r_speaker;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_code_n     = r_code;
        w_idx_n      = r_idx;
        w_div_n      = r_div;
        w_sample_n   = r_sample;
        w_rom_addr_n = r_rom_addr;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_code_n  = w_head;
                    w_idx_n   = '0;
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rom_addr_n = {r_code, r_idx};
                w_state_n    = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_sample_n = bus.rom_data;
                w_div_n    = DIV_LOAD;
                w_state_n  = S_HOLD;
            end
            S_HOLD: begin
                if (r_div != '0) begin
                    w_div_n = r_div - 1'b1;
                end else if (r_idx != IDX_MAX) begin
                    w_idx_n   = r_idx + 1'b1;
                    w_state_n = S_LOAD;
                end else if (!w_empty) begin
                    // chain straight into the next phoneme, no idle gap
                    w_pop     = 1'b1;
                    w_code_n  = w_head;
                    w_idx_n   = '0;
                    w_state_n = S_LOAD;
                end else begin
                    w_sample_n = SILENCE;
                    w_state_n  = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_idle     <= 1'b1;
            r_code     <= '0;
            r_idx      <= '0;
            r_div      <= '0;
            r_sample   <= SILENCE;
            r_rom_addr <= '0;
            r_pwm      <= '0;
            r_speaker  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_n;
            r_busy     <= (w_count_n == FULL_CNT);
            r_idle     <= (w_state_n == S_IDLE) && (w_count_n == '0);
            r_code     <= w_code_n;
            r_idx      <= w_idx_n;
            r_div      <= w_div_n;
            r_sample   <= w_sample_n;
            r_rom_addr <= w_rom_addr_n;
            r_pwm      <= r_pwm + 1'b1;
            r_speaker  <= (r_pwm < r_sample);
        end
    end

    assign bus.busy     = r_busy;
    assign bus.idle     = r_idle;
    assign bus.rom_addr = r_rom_addr;
    assign bus.speaker  = r_speaker;

endmodule

// File: tb/tb_phoneme_player.sv
// ----------------------------------------------------------------------------
// tb_phoneme_player
// Bench for phoneme_player at CLK_DIV=4, SAMPLE_BITS=2, FIFO_LOG2=2.
// A reference model (queue of codes plus a per-phoneme cycle counter) is
// stepped every clock and compared against busy/idle/rom_addr/speaker.
// ----------------------------------------------------------------------------
module tb_phoneme_player;

    localparam int CD    = 4;
    localparam int SB    = 2;
    localparam int FL    = 2;
    localparam int DEPTH = 1 << FL;
    localparam int TOTAL = CD * (1 << SB);

    logic clk;
    logic reset;
    logic       force_en;
    logic [7:0] force_val;

    phoneme_player_if #(.SAMPLE_BITS(SB)) bus ();

    phoneme_player #(
        .CLK_DIV     (CD),
        .SAMPLE_BITS (SB),
        .FIFO_LOG2   (FL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: returns the low address byte unless a fixed value is forced
    always_comb bus.rom_data = force_en ? force_val : bus.rom_addr[7:0];

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [5:0] mq[$];
    bit         m_play;
    int         m_t;
    logic [5:0] m_cur;
    logic [7:0] m_addr;
    logic [7:0] m_sample;
    logic [7:0] m_pwm;
    bit         m_busy, m_idle, m_spk;

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return force_en ? force_val : a;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_play = 0; m_t = 0; m_cur = '0; m_addr = '0;
        m_sample = 8'h80; m_pwm = '0;
        m_busy = 0; m_idle = 1; m_spk = 0;
    endtask

    task automatic model_step(input bit w, input logic [6:0] d);
        bit push;
        int sz;
        push = w && !m_busy;
        sz   = mq.size();
        m_spk = (m_pwm < m_sample);
        m_pwm = m_pwm + 8'd1;
        if (sz > 0 && (!m_play || m_t == TOTAL - 1)) begin
            m_cur  = mq.pop_front();
            m_play = 1;
            m_t    = 0;
        end else if (m_play && m_t == TOTAL - 1) begin
            m_play   = 0;
            m_sample = 8'h80;
        end else if (m_play) begin
            m_t++;
            // address appears once the LOAD cycle of each sample completes,
            // the sample one cycle later
            if (m_t % CD == 1) m_addr = {m_cur, 2'(m_t / CD)};
            if (m_t % CD == 2) m_sample = rom_val(m_addr);
        end
        if (push) mq.push_back(d[5:0]);
        m_busy = (mq.size() == DEPTH);
        m_idle = !m_play && (mq.size() == 0);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input bit w, input logic [6:0] d);
        bus.write = w;
        bus.data  = d;
        @(posedge clk); #1;
        model_step(w, d);
        bus.write = 1'b0;
        chk("busy",     32'(bus.busy),     32'(m_busy));
        chk("idle",     32'(bus.idle),     32'(m_idle));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        chk("speaker",  32'(bus.speaker),  32'(m_spk));
    endtask

    // called at #1 after an edge; reset covers one whole clock edge
    task automatic pulse_reset();
        bus.write = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_idle",     32'(bus.idle),     32'd1);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_speaker",  32'(bus.speaker),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         wr;
        logic [6:0] d;
        logic [7:0] addr;
        bit         busy;
        bit         idle;
    } vec_t;

    initial begin
        vec_t       vec [20];
        logic [6:0] burst [6];
        logic [5:0] seen[$];
        logic [7:0] prev;
        int         hi;
        int         mfalls, dfalls;
        bit         pb, db;
        logic [7:0] pwm_vals [3];

        // single write of 0x1d into an idle block: address advances every
        // CD cycles starting two edges after the write, idle 16 after LOAD
        vec[0] = '{1'b1, 7'h1d, 8'h00, 1'b0, 1'b0};
        for (int k = 1; k < 20; k++) begin
            vec[k].wr   = 1'b0;
            vec[k].d    = 7'h00;
            vec[k].addr = (k < 2) ? 8'h00 : 8'(8'h74 + ((k - 2) / 4 > 3 ? 3 : (k - 2) / 4));
            vec[k].busy = 1'b0;
            vec[k].idle = (k >= 17);
        end
        burst    = '{7'h1d, 7'h3b, 7'h21, 7'h35, 7'h02, 7'h11};
        pwm_vals = '{8'h00, 8'h80, 8'hFF};

        force_en  = 1'b0;
        force_val = 8'h00;
        bus.write = 1'b0;
        bus.data  = '0;
        reset     = 1'b1;
        #12;
        chk("init_busy",     32'(bus.busy),     32'd0);
        chk("init_idle",     32'(bus.idle),     32'd1);
        chk("init_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("init_speaker",  32'(bus.speaker),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // table: first edge after reset already accepts the write
        for (int i = 0; i < 20; i++) begin
            tick(vec[i].wr, vec[i].d);
            chk("tbl_addr", 32'(bus.rom_addr), 32'(vec[i].addr));
            chk("tbl_busy", 32'(bus.busy),     32'(vec[i].busy));
            chk("tbl_idle", 32'(bus.idle),     32'(vec[i].idle));
        end

        // bit 6 of the code is ignored
        tick(1'b1, 7'h7d); tick(1'b0, '0); tick(1'b0, '0);
        chk("bit6_7d_addr", 32'(bus.rom_addr), 32'h0f4);
        for (int i = 0; i < 20; i++) tick(1'b0, '0);
        tick(1'b1, 7'h3d); tick(1'b0, '0); tick(1'b0, '0);
        chk("bit6_3d_addr", 32'(bus.rom_addr), 32'h0f4);
        for (int i = 0; i < 20; i++) tick(1'b0, '0);

        // back-to-back burst; sixth write arrives while busy
        prev = bus.rom_addr;
        for (int i = 0; i < 100; i++) begin
            tick(i < 6, (i < 6) ? burst[i] : 7'h00);
            if (i == 4) chk("burst_busy", 32'(bus.busy), 32'd1);
            if (bus.rom_addr != prev && bus.rom_addr[1:0] == 2'b00)
                seen.push_back(bus.rom_addr[7:2]);
            prev = bus.rom_addr;
        end
        chk("burst_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < seen.size()) chk("burst_order", 32'(seen[i]), 32'(burst[i][5:0]));

        // write held high: pushes collide with pops while full
        mfalls = 0; dfalls = 0; pb = m_busy; db = bus.busy;
        for (int i = 0; i < 80; i++) begin
            tick(1'b1, 7'(i + 5));
            if (pb && !m_busy) mfalls++;
            if (db && !bus.busy) dfalls++;
            pb = m_busy; db = bus.busy;
        end
        chk("full_pop_busy_falls", 32'(dfalls), 32'(mfalls));
        chk("full_pop_seen", 32'(mfalls > 0), 32'd1);
        for (int i = 0; i < 90; i++) tick(1'b0, '0);

        // reset in the middle of a phoneme with commands queued
        tick(1'b1, 7'h1d); tick(1'b1, 7'h2a); tick(1'b1, 7'h15);
        for (int i = 0; i < 4; i++) tick(1'b0, '0);
        pulse_reset();
        tick(1'b1, 7'h21);
        for (int i = 0; i < 20; i++) tick(1'b0, '0);
        chk("post_rst_addr", 32'(bus.rom_addr), 32'h087);
        chk("post_rst_idle", 32'(bus.idle),     32'd1);

        // PWM duty over 256-cycle windows with a forced ROM value
        for (int v = 0; v < 3; v++) begin
            force_en  = 1'b1;
            force_val = pwm_vals[v];
            for (int i = 0; i < 40; i++) tick(1'b1, 7'h0a);
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                tick(1'b1, 7'h0a);
                hi += int'(bus.speaker);
            end
            chk("pwm_high_count", 32'(hi), (v == 0) ? 32'd0 : (v == 1) ? 32'd128 : 32'd255);
        end
        force_en = 1'b0;
        for (int i = 0; i < 100; i++) tick(1'b0, '0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) pulse_reset();
            tick($urandom_range(0, 5) == 0, 7'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
